// File: rtl/starfield_ramp_if.sv
`default_nettype none
// ============================================================================
// Module   : starfield_ramp_if
// Brief    : CPU register window, vblank input and starfield write port of
//            the speed/enable sequencer, bundled for one connection point.
// Revision : 1.0  initial release
// ============================================================================
interface starfield_ramp_if;
    logic       vblank;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_data_in;
    logic       cpu_write;
    logic       busy;
    logic       sf_addr;
    logic [7:0] sf_data;
    logic       sf_write;

    // The sequencer is the initiator of the starfield write port.
    modport master (
        input  vblank, cpu_addr, cpu_data_in, cpu_write,
        output busy, sf_addr, sf_data, sf_write
    );

    modport slave (
        output vblank, cpu_addr, cpu_data_in, cpu_write,
        input  busy, sf_addr, sf_data, sf_write
    );
endinterface
`default_nettype wire

// File: rtl/starfield_ramp.sv
`default_nettype none
// ============================================================================
// Module   : starfield_ramp
// Brief    : Steps the starfield speed toward a CPU-set target once per vblank
//            and forwards enable/speed updates as single-cycle writes.
//            Optional: STARFIELD_RAMP_FRAMEDIV_EN adds a frame divider at addr 3.
// Revision : 1.0  initial release
// ============================================================================
module starfield_ramp #(
    parameter logic [7:0] INIT_SPEED = 8'd0,
    parameter logic [7:0] INIT_STEP  = 8'd1
) (
    input wire               clk,
    input wire               rst,
    starfield_ramp_if.master bus
);
    localparam logic [1:0] c_ADDR_TARGET = 2'd0;
    localparam logic [1:0] c_ADDR_STEP   = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
    localparam logic [1:0] c_ADDR_DIV    = 2'd3;

    logic [7:0] r_target;
    logic [7:0] r_step;
    logic [7:0] r_live;
    logic       r_en;
    logic       r_pend_en;
    logic       r_pend_spd;
    logic       r_vblank_q;

    logic       w_vb_edge;
    logic       w_div_hit;
    logic       w_do_step;
    logic       w_cpu_ctrl;
    logic       w_snap;
    logic       w_srv_en;
    logic       w_srv_spd;
    logic [8:0] w_sum;
    logic [8:0] w_floor;
    logic [7:0] w_next_live;

    assign w_vb_edge  = bus.vblank & ~r_vblank_q;
    assign w_cpu_ctrl = bus.cpu_write & (bus.cpu_addr == c_ADDR_CTRL);
    assign w_snap     = w_cpu_ctrl & bus.cpu_data_in[1];

`ifdef STARFIELD_RAMP_FRAMEDIV_EN
    logic [7:0] r_div;
    logic [7:0] r_frame_cnt;

    assign w_div_hit = (r_frame_cnt == r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= 8'd0;
            r_frame_cnt <= 8'd0;
        end else if (bus.cpu_write && bus.cpu_addr == c_ADDR_DIV) begin
            r_div       <= bus.cpu_data_in;
            r_frame_cnt <= 8'd0;
        end else if (w_vb_edge) begin
            r_frame_cnt <= w_div_hit ? 8'd0 : r_frame_cnt + 8'd1;
        end
    end
`else
    assign w_div_hit = 1'b1;
`endif

    assign w_do_step = w_vb_edge & w_div_hit & (r_step != 8'd0) & (r_live != r_target);

    // Down-ramp clamp compares live against target+step so no underflow occurs.
    assign w_sum   = {1'b0, r_live} + {1'b0, r_step};
    assign w_floor = {1'b0, r_target} + {1'b0, r_step};

    always_comb begin
        w_next_live = r_live;
        if (r_live < r_target) begin
            w_next_live = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[7:0];
        end else begin
            w_next_live = ({1'b0, r_live} <= w_floor) ? r_target : r_live - r_step;
        end
    end

    assign w_srv_en  = r_pend_en;
    assign w_srv_spd = ~r_pend_en & r_pend_spd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target   <= INIT_SPEED;
            r_live     <= INIT_SPEED;
            r_step     <= INIT_STEP;
            r_en       <= 1'b0;
            r_vblank_q <= 1'b0;
            r_pend_en  <= 1'b1;
            r_pend_spd <= 1'b1;
        end else begin
            r_vblank_q <= bus.vblank;
            if (bus.cpu_write) begin
                case (bus.cpu_addr)
                    c_ADDR_TARGET: r_target <= bus.cpu_data_in;
                    c_ADDR_STEP:   r_step   <= bus.cpu_data_in;
                    c_ADDR_CTRL:   r_en     <= bus.cpu_data_in[0];
                    default:       ;
                endcase
            end
            // Edge math uses pre-write registers; a snap overrides the step.
            if (w_snap) begin
                r_live <= r_target;
            end else if (w_do_step) begin
                r_live <= w_next_live;
            end
            r_pend_en  <= w_cpu_ctrl | (r_pend_en & ~w_srv_en);
            r_pend_spd <= w_snap | w_do_step | (r_pend_spd & ~w_srv_spd);
        end
    end

    // Writes are driven straight from the pending flags so each carries the newest value.
    always_comb begin
        bus.sf_write = 1'b0;
        bus.sf_addr  = 1'b0;
        bus.sf_data  = 8'd0;
        if (!rst) begin
            if (w_srv_en) begin
                bus.sf_write = 1'b1;
                bus.sf_addr  = 1'b1;
                bus.sf_data  = {7'd0, r_en};
            end else if (w_srv_spd) begin
                bus.sf_write = 1'b1;
                bus.sf_addr  = 1'b0;
                bus.sf_data  = r_live;
            end
        end
    end

    assign bus.busy = (r_live != r_target);
endmodule
`default_nettype wire

// File: tb/tb_starfield_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_starfield_ramp
// Brief    : Directed per-cycle vector table plus frame-divider sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_starfield_ramp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    starfield_ramp_if bus ();

    starfield_ramp #(
        .INIT_SPEED(8'd0),
        .INIT_STEP (8'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vb;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic       ew;
        logic       ea;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic vb, input logic wr, input logic [1:0] a,
                       input logic [7:0] d, input logic ew, input logic ea,
                       input logic [7:0] ed, input logic eb);
        vec_t v;
        v = '{rst: r, vb: vb, wr: wr, addr: a, data: d, ew: ew, ea: ea, ed: ed, eb: eb};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic vb, input logic wr,
                         input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        rst             = r;
        bus.vblank      = vb;
        bus.cpu_write   = wr;
        bus.cpu_addr    = a;
        bus.cpu_data_in = d;
        #1;
    endtask

    task automatic check(input string name, input logic ew, input logic ea,
                         input logic [7:0] ed, input logic eb);
        logic ok;
        checks++;
        ok = (bus.sf_write === ew) && (bus.busy === eb);
        if (ew) ok = ok && (bus.sf_addr === ea) && (bus.sf_data === ed);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got write=%b addr=%b data=%0d busy=%b, want write=%b addr=%b data=%0d busy=%b",
                     name, bus.sf_write, bus.sf_addr, bus.sf_data, bus.busy, ew, ea, ed, eb);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.vblank = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr = 2'd0;
        bus.cpu_data_in = 8'd0;

        //   rst vb wr addr data    ew ea ed    eb
        add(1, 0, 0, 0, 0,       0, 0, 0,   0);   // in reset
        add(1, 0, 0, 0, 0,       0, 0, 0,   0);
        add(0, 0, 0, 0, 0,       1, 1, 0,   0);   // enable=0 first
        add(0, 0, 0, 0, 0,       1, 0, 0,   0);   // then speed=INIT_SPEED
        add(0, 0, 1, 0, 20,      0, 0, 0,   0);   // target=20
        add(0, 0, 1, 1, 8,       0, 0, 0,   1);   // step=8
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // edge 1
        add(0, 0, 0, 0, 0,       1, 0, 8,   1);
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // edge 2
        add(0, 0, 0, 0, 0,       1, 0, 16,  1);
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // edge 3 (clamped)
        add(0, 1, 0, 0, 0,       1, 0, 20,  0);
        add(0, 0, 0, 0, 0,       0, 0, 0,   0);
        add(0, 1, 0, 0, 0,       0, 0, 0,   0);   // edge 4: at target
        add(0, 0, 0, 0, 0,       0, 0, 0,   0);
        add(0, 0, 1, 0, 3,       0, 0, 0,   0);   // target=3
        add(0, 0, 0, 0, 0,       0, 0, 0,   1);
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // down edge 1
        add(0, 1, 0, 0, 0,       1, 0, 12,  1);   // vblank held
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // held: no step
        add(0, 0, 0, 0, 0,       0, 0, 0,   1);
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // down edge 2
        add(0, 0, 0, 0, 0,       1, 0, 4,   1);
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);   // down edge 3 (clamped)
        add(0, 0, 0, 0, 0,       1, 0, 3,   0);
        add(0, 0, 1, 0, 100,     0, 0, 0,   0);   // target=100
        add(0, 0, 1, 1, 0,       0, 0, 0,   1);   // step=0
        add(0, 1, 0, 0, 0,       0, 0, 0,   1);
        add(0, 0, 0, 0, 0,       0, 0, 0,   1);   // step 0: no write
        add(0, 0, 1, 0, 0,       0, 0, 0,   1);   // target=0
        add(0, 0, 1, 2, 8'h02,   0, 0, 0,   1);   // snap, en=0
        add(0, 0, 1, 0, 8,       1, 1, 0,   0);   // target=8
        add(0, 0, 1, 1, 8,       1, 0, 0,   1);   // step=8
        add(0, 1, 1, 2, 8'h01,   0, 0, 0,   1);   // ctrl with edge
        add(0, 0, 0, 0, 0,       1, 1, 1,   0);
        add(0, 0, 0, 0, 0,       1, 0, 8,   0);
        add(0, 0, 0, 0, 0,       0, 0, 0,   0);
        add(0, 0, 1, 0, 200,     0, 0, 0,   0);   // target=200
        add(0, 0, 1, 2, 8'h03,   0, 0, 0,   1);   // enable + snap
        add(0, 0, 0, 0, 0,       1, 1, 1,   0);
        add(0, 0, 0, 0, 0,       1, 0, 200, 0);
        add(0, 0, 0, 0, 0,       0, 0, 0,   0);
        add(0, 0, 1, 0, 50,      0, 0, 0,   0);   // target=50
        add(1, 0, 0, 0, 0,       0, 0, 0,   1);   // reset mid-ramp
        add(0, 0, 0, 0, 0,       1, 1, 0,   0);
        add(0, 0, 0, 0, 0,       1, 0, 0,   0);
        add(0, 0, 0, 0, 0,       0, 0, 0,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vb, vecs[i].wr, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ea, vecs[i].ed, vecs[i].eb);
        end

        // Frame divider: div=2 steps only every third edge; without it addr 3 is ignored.
        drive(0, 0, 1, 1, 8);
        check("div_step_wr", 0, 0, 0, 0);
        drive(0, 0, 1, 3, 2);
        check("div_div_wr", 0, 0, 0, 0);
        drive(0, 0, 1, 0, 24);
        check("div_tgt_wr", 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            logic       ew;
            logic [7:0] ed;
            logic       eb;
`ifdef STARFIELD_RAMP_FRAMEDIV_EN
            ew = (k % 3 == 0);
            ed = 8'(8 * (k / 3));
            eb = (k < 9);
`else
            ew = (k <= 3);
            ed = 8'(8 * k);
            eb = (k < 3);
`endif
            drive(0, 1, 0, 0, 0);
            check($sformatf("div_edge%0d", k), 0, 0, 0, 1'(k == 1 || eb || ew));
            drive(0, 0, 0, 0, 0);
            check($sformatf("div_after%0d", k), ew, 0, ed, eb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/starfield_ramp.md
# starfield_ramp

Autonomous speed/enable sequencer that drives the starfield's write port (address 0 = speed, address 1 = enable) on behalf of the CPU. The CPU programs a target speed, a per-frame step and an enable bit through a small register window. On every vblank the block moves the live speed one step toward the target and issues the matching single-cycle write, so fly-in/fly-out effects need no per-frame CPU work. It sits between the CPU bus decode and the starfield instance, as the initiator of that register interface.

## Interface
- INIT_SPEED, 8'd0, speed loaded into the live and target speed at reset
- INIT_STEP, 8'd1, per-frame step loaded at reset
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- vblank  in  1  vertical blank level from video timing
- cpu_addr  in  2  CPU register select: 0 target, 1 step, 2 control, 3 frame divider (only with the macro)
- cpu_data_in  in  8  CPU write data
- cpu_write  in  1  CPU write strobe, one cycle per write
- busy  out  1  high while live speed != target
- sf_addr  out  1  starfield write address: 0 speed, 1 enable
- sf_data  out  8  starfield write data
- sf_write  out  1  starfield write strobe, one cycle per write

## Operation
- Registers: target[7:0], step[7:0], live[7:0], en_reg, plus pending flags pend_en and pend_spd.
- CPU writes: addr 0 sets target. addr 1 sets step. addr 2: bit0 sets en_reg and raises pend_en; bit1 = snap, which sets live=target and raises pend_spd. Other bits are ignored.
- vblank rising edge: detected when vblank=1 and vblank_q=0, with vblank_q registered. On the edge, if step!=0 and live!=target, live moves toward target; otherwise nothing happens.
  - Up: 9-bit sum live+step; if sum >= target then live=target, else live=sum.
  - Down: if live-step <= target (computed 9-bit, no underflow) then live=target, else live=live-step.
  - Any change raises pend_spd.
- Output arbiter: at most one write per cycle. Enable has priority.
  - pend_en → sf_write=1, sf_addr=1, sf_data={7'b0,en_reg}, clear pend_en.
  - Else pend_spd → sf_write=1, sf_addr=0, sf_data=live, clear pend_spd.
- A flag raised in the same cycle it is being serviced stays set. The output always carries the newest en_reg/live value.
- Redundant events coalesce: one pending flag per address, never queued twice.
- busy = (live != target), combinational from registers.

## Timing
- Reset: sf_write=0, sf_addr=0, sf_data=0, live=target=INIT_SPEED, step=INIT_STEP, en_reg=0, vblank_q=0.
- Reset also sets pend_en=pend_spd=1, so the starfield (which has no enable reset) receives enable=0 in the first cycle after rst falls and speed=INIT_SPEED in the second.
- Edge in cycle N → live updates at N+1 and sf_write is high in cycle N+1 with the new value, unless pend_en also wins at N+1; in that case the speed write moves to N+2.
- CPU control write in cycle N → enable write in cycle N+1. A snap in the same write produces the speed write at N+2.
- Target or step written mid-ramp takes effect at the next edge; no write is issued until then, except on snap.
- CPU write coincident with a vblank edge: the CPU write's new values are used by that edge's step computation in the same cycle? No. The edge uses register values from before the write; the write lands in parallel, and the last write wins for live (snap overrides step).
- vblank held high produces no further steps. Reset mid-ramp aborts and reruns the reset write sequence.

## Configuration
- STARFIELD_RAMP_FRAMEDIV_EN defined: adds div[7:0] at cpu_addr 3 (reset 0) and a frame counter. Steps occur only on every (div+1)th vblank edge. The counter clears on reset and on any write to addr 3.
- Undefined: writes to addr 3 are ignored and every edge is eligible to step.

## Test plan
- Release reset with INIT_SPEED=0 → cycle 1: sf_addr=1, sf_data=0, sf_write=1; cycle 2: sf_addr=0, sf_data=0, sf_write=1; then sf_write=0.
- target=20, step=8, live=0, three vblank edges → speed writes 8, 16, 20, one cycle after each edge; busy drops after the third; a fourth edge produces no write.
- live=20, target=3, step=8 → writes 12, 4, 3; with step=0 no write and busy stays 1.
- Control write 0x01 in the same cycle as a vblank edge with live=0, target=8, step=8 → cycle N+1 enable write data 1, cycle N+2 speed write data 8.
- Control write 0x03 with target=200 → enable write, then speed write 200 on the next cycle, with no vblank needed.
- With STARFIELD_RAMP_FRAMEDIV_EN defined, div=2, target=24, step=8 → speed writes only on edges 3, 6, 9, with values 8, 16, 24.
